char_buffer_mem: RTL and testbench

- Parametrised character/data buffer for the text display path.
- Successor of the single-port byte RAM with a flat character dump. Adds:
  - a registered CPU read/write port, selectable word- or byte-aligned;
  - an independent registered display read port;
  - range checking;
  - a hardware clear engine that fills the whole buffer with a fill character.
- Sits between the core's store/load path and the VGA/text renderer.

---
 rtl/char_buffer_mem.sv | 75 +++++++
 tb/tb_char_buffer_mem.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/char_buffer_mem.sv
// char_buffer_mem: character buffer with registered CPU port, display read port and a clear engine.
module char_buffer_mem #(
  parameter int DW = 8,
  parameter int DEPTH = 640,
  parameter int AW = $clog2(DEPTH),
  parameter int WORD_ADDR = 1,
  parameter logic [DW-1:0] FILL = DW'(8'h20)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic [31:0]   cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic          cpu_err,
  output logic          cpu_ready,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_data,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_done
);
  localparam logic IDLE = 1'b0;
  localparam logic CLEAR = 1'b1;
  logic [DW-1:0] mem [DEPTH];
  logic          state;
  logic [AW-1:0] cnt;
  logic [31:0]   idx;
  logic [AW-1:0] widx;
  logic          in_range, wr_acc, rd_ok, last;
  assign busy      = state == CLEAR;
  assign cpu_ready = ~busy;
  // the full index is range-checked so high address bits never alias into the buffer
  assign idx      = WORD_ADDR != 0 ? {2'b00, cpu_addr[31:2]} : cpu_addr;
  assign in_range = idx < DEPTH;
  assign widx     = idx[AW-1:0];
  assign wr_acc   = cpu_we & cpu_ready;
  assign rd_ok    = cpu_re & ~cpu_we & cpu_ready;
  assign last     = cnt == AW'(DEPTH - 1);
  always_ff @(posedge clk)
    if (busy) mem[cnt] <= FILL;
    else if (wr_acc && in_range) mem[widx] <= cpu_wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= busy & last;
      if (!busy) begin
        if (clr_req) begin
          state <= CLEAR;
          cnt   <= '0;
        end
      end else begin
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) state <= IDLE;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      cpu_err    <= 1'b0;
    end else begin
      cpu_rvalid <= rd_ok;
      cpu_err    <= (rd_ok | wr_acc) & ~in_range;
      if (rd_ok) cpu_rdata <= in_range ? mem[widx] : '0;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) disp_data <= '0;
    else disp_data <= 32'(disp_addr) < DEPTH ? mem[disp_addr] : '0;
endmodule

// File: tb/tb_char_buffer_mem.sv
// tb_char_buffer_mem: directed checks of CPU access, range errors, display port and clear engine.
module tb_char_buffer_mem;
  logic       clk, rst, cpu_we, cpu_re, cpu_rvalid, cpu_err, cpu_ready, clr_req, busy, clr_done;
  logic [31:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata, disp_data;
  logic [9:0] disp_addr;
  int total = 0, bad = 0, n;

  char_buffer_mem dut (
    .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_err(cpu_err),
    .cpu_ready(cpu_ready), .disp_addr(disp_addr), .disp_data(disp_data), .clr_req(clr_req),
    .busy(busy), .clr_done(clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    tick;
    cpu_we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] exp, input string tag);
    cpu_re = 1'b1; cpu_addr = a;
    tick;
    cpu_re = 1'b0;
    chk({tag, "_rvalid"}, 32'(cpu_rvalid), 1);
    chk({tag, "_rdata"}, 32'(cpu_rdata), 32'(exp));
    chk({tag, "_err"}, 32'(cpu_err), 0);
  endtask

  task automatic run_clear(input string tag);
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      n++;
      if (n == 5) wr(32'h1C, 8'h77);
      else if (n == 6) begin
        chk({tag, "_busy_err"}, 32'(cpu_err), 0);
        chk({tag, "_busy_rvalid"}, 32'(cpu_rvalid), 0);
        chk({tag, "_busy_ready"}, 32'(cpu_ready), 0);
        chk({tag, "_busy_done"}, 32'(clr_done), 0);
        tick;
      end else tick;
    end
    chk({tag, "_busy_cycles"}, 32'(n), 640);
    chk({tag, "_done"}, 32'(clr_done), 1);
    chk({tag, "_ready"}, 32'(cpu_ready), 1);
    tick;
    chk({tag, "_done_pulse"}, 32'(clr_done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    disp_addr = '0; clr_req = 1'b0;
    #12;
    chk("rst_rdata", 32'(cpu_rdata), 0);
    chk("rst_rvalid", 32'(cpu_rvalid), 0);
    chk("rst_err", 32'(cpu_err), 0);
    chk("rst_disp", 32'(disp_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(clr_done), 0);
    chk("rst_ready", 32'(cpu_ready), 1);
    rst = 1'b0;
    tick;
    wr(32'h10, 8'h41);
    chk("wr_err", 32'(cpu_err), 0);
    disp_addr = 10'd4;
    rd(32'h10, 8'h41, "rd4");
    chk("disp4", 32'(disp_data), 32'h41);
    tick;
    chk("rvalid_pulse", 32'(cpu_rvalid), 0);
    chk("rdata_hold", 32'(cpu_rdata), 32'h41);
    wr(32'h0, 8'h55);
    wr(32'hA00, 8'h99);
    chk("oor_wr_err", 32'(cpu_err), 1);
    tick;
    chk("oor_err_pulse", 32'(cpu_err), 0);
    wr(32'h1000_0010, 8'h99);
    chk("hi_wr_err", 32'(cpu_err), 1);
    cpu_re = 1'b1; cpu_addr = 32'hA00;
    tick;
    cpu_re = 1'b0;
    chk("oor_rd_rvalid", 32'(cpu_rvalid), 1);
    chk("oor_rd_rdata", 32'(cpu_rdata), 0);
    chk("oor_rd_err", 32'(cpu_err), 1);
    rd(32'h0, 8'h55, "alias0");
    rd(32'h10, 8'h41, "alias4");
    disp_addr = 10'd700;
    tick;
    chk("disp_oor", 32'(disp_data), 0);
    wr(32'h9FC, 8'h55);
    rd(32'h9FC, 8'h55, "pre639");
    run_clear("clr1");
    rd(32'h0, 8'h20, "clr_idx0");
    rd(32'h9FC, 8'h20, "clr_idx639");
    rd(32'h1C, 8'h20, "clr_idx7");
    disp_addr = 10'd3;
    wr(32'hC, 8'h7E);
    chk("rdw_old", 32'(disp_data), 32'h20);
    tick;
    chk("rdw_new", 32'(disp_data), 32'h7E);
    wr(32'd396, 8'h44);
    wr(32'd400, 8'h33);
    wr(32'd404, 8'h66);
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    chk("clr2_busy", 32'(busy), 1);
    for (int i = 0; i < 100; i++) tick;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ready", 32'(cpu_ready), 1);
    chk("midrst_done", 32'(clr_done), 0);
    rst = 1'b0;
    tick;
    rd(32'd0, 8'h20, "part_idx0");
    rd(32'd396, 8'h20, "part_idx99");
    rd(32'd400, 8'h33, "part_idx100");
    rd(32'd404, 8'h66, "part_idx101");
    run_clear("clr3");
    rd(32'd400, 8'h20, "full_idx100");
    rd(32'h9FC, 8'h20, "full_idx639");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
